// File: rtl/ifm_pingpong_buff_pkg.sv
// ifm_pingpong_buff_pkg: shared bank-state type and occupancy width for the IFM ping-pong buffer.
package ifm_pingpong_buff_pkg;
    typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_state_t;
    localparam int OCC_W = 2;
endpackage

// File: rtl/ifm_bank.sv
// ifm_bank: NUM_CH x DATA_WIDTH register bank with a single lane write port, all lanes read in parallel.
module ifm_bank #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CH     = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         we,
    input  logic [$clog2(NUM_CH)-1:0]    idx,
    input  logic [DATA_WIDTH-1:0]        din,
    output logic [NUM_CH*DATA_WIDTH-1:0] data
);
    logic [NUM_CH-1:0][DATA_WIDTH-1:0] mem;

    assign data = mem;

    always_ff @(posedge clk or posedge rst)
        if (rst)
            mem <= '0;
        else if (we)
            mem[idx] <= din;
endmodule

// File: rtl/ifm_pingpong_buff.sv
// ifm_pingpong_buff: serial-in, bank-parallel-out double buffer for IFM words.
// Define IFM_BUFF_REPLAY_EN to add rd_keep, which re-presents a bank instead of releasing it.
module ifm_pingpong_buff
    import ifm_pingpong_buff_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CH     = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         wr_valid,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    output logic                         wr_ready,
    output logic                         rd_valid,
    output logic [NUM_CH*DATA_WIDTH-1:0] rd_data,
    input  logic                         rd_ready,
`ifdef IFM_BUFF_REPLAY_EN
    input  logic                         rd_keep,
`endif
    output logic [OCC_W-1:0]             occupancy
);
    localparam int IDX_W = $clog2(NUM_CH);

    bank_state_t                 st_q [2];
    bank_state_t                 st_d [2];
    logic                        wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [IDX_W-1:0]            wr_idx_q, wr_idx_d;
    logic                        wr_fire, rd_fire, keep, last;
    logic [NUM_CH*DATA_WIDTH-1:0] bank_data [2];

`ifdef IFM_BUFF_REPLAY_EN
    assign keep = rd_keep;
`else
    assign keep = 1'b0;
`endif

    assign wr_ready  = st_q[wr_bank_q] != FULL;
    assign rd_valid  = st_q[rd_bank_q] == FULL;
    assign rd_data   = bank_data[rd_bank_q];
    assign wr_fire   = wr_valid & wr_ready & ~clear;
    assign rd_fire   = rd_valid & rd_ready & ~clear;
    assign last      = wr_idx_q == IDX_W'(NUM_CH - 1);
    assign occupancy = OCC_W'(st_q[0] == FULL) + OCC_W'(st_q[1] == FULL);

    // A write can only target a non-FULL bank and a read only a FULL one, so both may update st_d safely.
    always_comb begin
        st_d      = st_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_idx_d  = wr_idx_q;
        if (clear) begin
            st_d[0]   = EMPTY;
            st_d[1]   = EMPTY;
            wr_bank_d = 1'b0;
            rd_bank_d = 1'b0;
            wr_idx_d  = '0;
        end else begin
            if (wr_fire) begin
                st_d[wr_bank_q] = last ? FULL : FILLING;
                wr_idx_d        = last ? '0 : wr_idx_q + IDX_W'(1);
                wr_bank_d       = wr_bank_q ^ last;
            end
            if (rd_fire && !keep) begin
                st_d[rd_bank_q] = EMPTY;
                rd_bank_d       = ~rd_bank_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            st_q[0]   <= EMPTY;
            st_q[1]   <= EMPTY;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_idx_q  <= '0;
        end else begin
            st_q      <= st_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_idx_q  <= wr_idx_d;
        end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        ifm_bank #(.DATA_WIDTH(DATA_WIDTH), .NUM_CH(NUM_CH)) u_bank (
            .clk  (clk),
            .rst  (rst),
            .we   (wr_fire && wr_bank_q == 1'(b)),
            .idx  (wr_idx_q),
            .din  (wr_data),
            .data (bank_data[b])
        );
    end
endmodule

// File: tb/tb_ifm_pingpong_buff.sv
// tb_ifm_pingpong_buff: vector table plus bank-queue scoreboard for ifm_pingpong_buff (NUM_CH=4, DATA_WIDTH=8).
module tb_ifm_pingpong_buff;
    localparam int NC = 4;
`ifdef IFM_BUFF_REPLAY_EN
    localparam bit REPLAY = 1'b1;
`else
    localparam bit REPLAY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, clear, wr_valid, rd_ready, rd_keep;
    logic [7:0]  wr_data;
    logic        wr_ready, rd_valid;
    logic [31:0] rd_data;
    logic [1:0]  occupancy;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] sb [$];
    logic [31:0] acc;
    int          n;

    typedef struct {
        logic        wv;
        logic [7:0]  wd;
        logic        rr;
        logic        cl;
        logic        ewr;
        logic        erv;
        logic [1:0]  eocc;
        logic [31:0] edata;
    } vec_t;
    vec_t tv [35];

    ifm_pingpong_buff #(.DATA_WIDTH(8), .NUM_CH(NC)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_ready  (rd_ready),
`ifdef IFM_BUFF_REPLAY_EN
        .rd_keep   (rd_keep),
`endif
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs and compare state-derived outputs against the bank queue.
    task automatic drive(input logic wv, input logic [7:0] wd, input logic rr, input logic cl, input logic kp);
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
        clear    = cl;
        rd_keep  = kp;
        #1;
        chk("sb_wr_ready", wr_ready, sb.size() < 2);
        chk("sb_rd_valid", rd_valid, sb.size() > 0);
        chk("sb_occupancy", occupancy, sb.size());
        if (sb.size() > 0)
            chk("sb_rd_data", rd_data, sb[0]);
    endtask

    task automatic step();
        bit wacc, racc;
        wacc = wr_valid && sb.size() < 2;
        racc = rd_ready && sb.size() > 0 && !(REPLAY && rd_keep);
        if (clear) begin
            sb.delete();
            n = 0;
        end else begin
            if (racc)
                void'(sb.pop_front());
            if (wacc) begin
                acc[n*8 +: 8] = wr_data;
                n++;
                if (n == NC) begin
                    sb.push_back(acc);
                    n = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input logic wv, input logic [7:0] wd, input logic rr, input logic cl, input logic kp);
        drive(wv, wd, rr, cl, kp);
        step();
    endtask

    initial begin
        tv[0]  = '{1, 8'h11, 0, 0, 1, 0, 0, 32'h0};
        tv[1]  = '{1, 8'h22, 0, 0, 1, 0, 0, 32'h0};
        tv[2]  = '{1, 8'h33, 0, 0, 1, 0, 0, 32'h0};
        tv[3]  = '{1, 8'h44, 0, 0, 1, 0, 0, 32'h0};
        tv[4]  = '{0, 8'h00, 0, 0, 1, 1, 1, 32'h44332211};
        tv[5]  = '{0, 8'h00, 1, 0, 1, 1, 1, 32'h44332211};
        tv[6]  = '{0, 8'h00, 0, 0, 1, 0, 0, 32'h0};
        tv[7]  = '{1, 8'h01, 0, 0, 1, 0, 0, 32'h0};
        tv[8]  = '{1, 8'h02, 0, 0, 1, 0, 0, 32'h0};
        tv[9]  = '{1, 8'h03, 0, 0, 1, 0, 0, 32'h0};
        tv[10] = '{1, 8'h04, 0, 0, 1, 0, 0, 32'h0};
        tv[11] = '{1, 8'h05, 0, 0, 1, 1, 1, 32'h04030201};
        tv[12] = '{1, 8'h06, 0, 0, 1, 1, 1, 32'h04030201};
        tv[13] = '{1, 8'h07, 0, 0, 1, 1, 1, 32'h04030201};
        tv[14] = '{1, 8'h08, 0, 0, 1, 1, 1, 32'h04030201};
        tv[15] = '{1, 8'h09, 0, 0, 0, 1, 2, 32'h04030201};
        tv[16] = '{1, 8'h0A, 1, 0, 0, 1, 2, 32'h04030201};
        tv[17] = '{0, 8'h00, 0, 0, 1, 1, 1, 32'h08070605};
        tv[18] = '{1, 8'h21, 0, 0, 1, 1, 1, 32'h08070605};
        tv[19] = '{1, 8'h22, 0, 0, 1, 1, 1, 32'h08070605};
        tv[20] = '{1, 8'h23, 0, 0, 1, 1, 1, 32'h08070605};
        tv[21] = '{1, 8'h24, 1, 0, 1, 1, 1, 32'h08070605};
        tv[22] = '{0, 8'h00, 0, 0, 1, 1, 1, 32'h24232221};
        tv[23] = '{0, 8'h00, 1, 0, 1, 1, 1, 32'h24232221};
        tv[24] = '{0, 8'h00, 0, 0, 1, 0, 0, 32'h0};
        tv[25] = '{1, 8'h31, 0, 0, 1, 0, 0, 32'h0};
        tv[26] = '{1, 8'h32, 0, 0, 1, 0, 0, 32'h0};
        tv[27] = '{1, 8'h33, 0, 1, 1, 0, 0, 32'h0};
        tv[28] = '{1, 8'h41, 0, 0, 1, 0, 0, 32'h0};
        tv[29] = '{1, 8'h42, 0, 0, 1, 0, 0, 32'h0};
        tv[30] = '{1, 8'h43, 0, 0, 1, 0, 0, 32'h0};
        tv[31] = '{1, 8'h44, 0, 0, 1, 0, 0, 32'h0};
        tv[32] = '{0, 8'h00, 0, 0, 1, 1, 1, 32'h44434241};
        tv[33] = '{0, 8'h00, 1, 0, 1, 1, 1, 32'h44434241};
        tv[34] = '{0, 8'h00, 0, 0, 1, 0, 0, 32'h0};

        rst = 1'b1; clear = 1'b0; wr_valid = 1'b0; wr_data = 8'h00; rd_ready = 1'b0; rd_keep = 1'b0;
        n = 0; acc = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_wr_ready", wr_ready, 1);
        chk("reset_rd_valid", rd_valid, 0);
        chk("reset_rd_data", rd_data, 0);
        chk("reset_occupancy", occupancy, 0);
        rst = 1'b0;

        for (int i = 0; i < 35; i++) begin
            drive(tv[i].wv, tv[i].wd, tv[i].rr, tv[i].cl, 1'b0);
            chk($sformatf("vec%0d_wr_ready", i), wr_ready, tv[i].ewr);
            chk($sformatf("vec%0d_rd_valid", i), rd_valid, tv[i].erv);
            chk($sformatf("vec%0d_occupancy", i), occupancy, tv[i].eocc);
            if (tv[i].erv)
                chk($sformatf("vec%0d_rd_data", i), rd_data, tv[i].edata);
            step();
        end

        // Reset while both banks are full and stalled.
        for (int i = 0; i < 8; i++)
            tick(1, 8'h50 + 8'(i), 0, 0, 0);
        tick(1, 8'h5F, 0, 0, 0);
        chk("stall_occupancy", occupancy, 2);
        rst = 1'b1;
        #2;
        chk("async_rst_occupancy", occupancy, 0);
        chk("async_rst_rd_valid", rd_valid, 0);
        chk("async_rst_wr_ready", wr_ready, 1);
        chk("async_rst_rd_data", rd_data, 0);
        sb.delete();
        n = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(0, 8'h00, 1, 0, 0);
        tick(0, 8'h00, 1, 0, 0);

        // Reset mid-fill: partial words must not leak into the next bank.
        tick(1, 8'h61, 0, 0, 0);
        tick(1, 8'h62, 0, 0, 0);
        rst = 1'b1;
        sb.delete();
        n = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++)
            tick(1, 8'h71 + 8'(i), 0, 0, 0);
        chk("midfill_rd_data", rd_data, 32'h74737271);
        tick(0, 8'h00, 1, 0, 0);

        // Clear with both banks full, together with a read request.
        for (int i = 0; i < 8; i++)
            tick(1, 8'h80 + 8'(i), 0, 0, 0);
        tick(1, 8'hEE, 1, 1, 0);
        chk("clear_full_occupancy", occupancy, 0);
        chk("clear_full_wr_ready", wr_ready, 1);
        tick(0, 8'h00, 0, 0, 0);

`ifdef IFM_BUFF_REPLAY_EN
        for (int i = 0; i < 4; i++)
            tick(1, 8'hA1 + 8'(i), 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            chk("replay_keep_data", rd_data, 32'hA4A3A2A1);
            tick(0, 8'h00, 1, 0, 1);
        end
        chk("replay_last_data", rd_data, 32'hA4A3A2A1);
        tick(0, 8'h00, 1, 0, 0);
        chk("replay_released", rd_valid, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
